// File: rtl/gf_mult_serial.sv
// Bit-serial GF(2^M) multiplier: one multiplier bit per clock, MSB first, reduced
// modulo POLY, with valid/ready handshakes on both the operand and product sides.
module gf_mult_serial #(
   parameter int unsigned M    = 8,
   parameter logic [M:0]  POLY = 'h11B
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] product,
   output logic         busy
);

   localparam int unsigned CW = $clog2(M);
   localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t         state_q;
   logic [M-1:0]   a_q, b_q, acc_q, acc_d, product_q;
   logic [CW-1:0]  cnt_q;
   logic           in_ready_q, out_valid_q, busy_q;

   // Horner step: multiply the running sum by x, fold the overflow back through
   // the low bits of POLY, then add in a when the current multiplier bit is set.
   always_comb begin
      acc_d = {acc_q[M-2:0], 1'b0};
      if (acc_q[M-1]) acc_d = acc_d ^ POLY[M-1:0];
      if (b_q[cnt_q]) acc_d = acc_d ^ a_q;
   end

   // NOTE: every register, operands included, is reset so an abort leaves no stale result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  acc_q      <= '0;
                  cnt_q      <= CNT_LAST;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  product_q   <= acc_d;
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               // Acceptance waits for the IDLE cycle so the two handshakes never share an edge.
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_gf_mult_serial.sv
// Self-checking bench for gf_mult_serial (GF(2^8), AES polynomial): directed
// vectors, backpressure, mid-run reset, back-to-back and randomized traffic.
module tb_gf_mult_serial;

   localparam int M = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] product;
   logic         busy;

   int checks = 0;
   int errors = 0;

   gf_mult_serial #(.M(M), .POLY(9'h11B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;

   // Reference: full carry-less product, then long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (y[i]) p = p ^ (15'(x) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
      return p[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one operand pair at a negedge with in_ready high; returns after the accepting edge.
   task automatic send(input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("in_ready before send", in_ready, 1);
      a = x;
      b = y;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts edges from the accepting edge until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      vec_t vecs[5];
      int   lat;

      vecs[0] = '{8'h57, 8'h83, 8'hC1};
      vecs[1] = '{8'h02, 8'h80, 8'h1B};
      vecs[2] = '{8'h01, 8'hA5, 8'hA5};
      vecs[3] = '{8'h00, 8'hFF, 8'h00};
      vecs[4] = '{8'hFF, 8'h00, 8'h00};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset product", product, 0);
      check("reset busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle in_ready", in_ready, 1);
      check("idle out_valid", out_valid, 0);

      // Directed table, consumer always ready
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b);
         check("busy during run", busy, 1);
         wait_valid(lat);
         check($sformatf("vec%0d latency", i), lat, M);
         check($sformatf("vec%0d product", i), product, vecs[i].exp);
         check($sformatf("vec%0d in_ready in done", i), in_ready, 0);
         @(negedge clk);
         check($sformatf("vec%0d out_valid held 1 cycle", i), out_valid, 0);
         check($sformatf("vec%0d in_ready after handshake", i), in_ready, 1);
      end

      // Backpressure: result held, new operands ignored while stalled
      out_ready = 1'b0;
      send(8'h57, 8'h13);
      wait_valid(lat);
      check("stall latency", lat, M);
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall out_valid", out_valid, 1);
         check("stall product", product, 8'hFE);
         check("stall in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("release out_valid", out_valid, 0);
      check("release in_ready", in_ready, 1);
      check("release product kept", product, 8'hFE);
      repeat (2) @(negedge clk);
      check("stalled in_valid ignored", busy, 0);

      // Asynchronous reset in the middle of a run
      send(8'h57, 8'h83);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         check("no result after abort", seen, 0);
      end

      // Back-to-back with in_valid held high
      begin
         logic [7:0] pa[3], pb[3], got[$];
         int         t_res[$];
         int         p = 0;
         for (int i = 0; i < 3; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
         end
         for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid && out_ready) begin
               got.push_back(product);
               t_res.push_back(cyc);
            end
            if (in_ready) begin
               if (p < 3) begin
                  a = pa[p]; b = pb[p]; in_valid = 1'b1; p++;
               end else begin
                  in_valid = 1'b0;
               end
            end
            @(negedge clk);
         end
         in_valid = 1'b0;
         check("b2b result count", got.size(), 3);
         for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("b2b product %0d", i), got[i], gf_mul(pa[i], pb[i]));
         for (int i = 1; i < 3 && i < t_res.size(); i++)
            check($sformatf("b2b spacing %0d", i), t_res[i] - t_res[i-1], M + 2);
      end

      // Randomized traffic with consumer stalls against the reference model
      begin
         logic [7:0] exp_q[$];
         int accepted = 0, received = 0, cyc = 0;
         while (received < 1000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_ready && accepted < 1000 && $urandom_range(0, 3) != 0) begin
               a = 8'($urandom);
               b = 8'($urandom);
               in_valid = 1'b1;
               exp_q.push_back(gf_mul(a, b));
               accepted++;
            end else begin
               in_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
               received++;
               if (exp_q.size() == 0) check("rand unexpected result", 1, 0);
               else check("rand product", product, exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
         end
         in_valid = 1'b0;
         check("rand received count", received, 1000);
         check("rand none outstanding", exp_q.size(), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
